// File: rtl/quad_decoder_pkg.sv
// rtl/quad_decoder_pkg.sv - shared types, phase constants and step decoder for quad_decoder
//
// Purpose: common definitions used by the quadrature decoder, its sub-module
// and its output interface.
//   state_t      : decoder FSM states (INIT, TRACK)
//   PH_*         : 2-bit {A,B} phase codes along the up sequence 00-10-11-01
//   step_t       : decode result {valid, down, illegal}
//   decode_step  : classifies the move from a previous to a current phase pair

package quad_decoder_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam int         ERR_CNT_W   = 8;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  typedef struct packed {
    logic valid;
    logic down;
    logic illegal;
  } step_t;

  // Successor of a phase pair when the encoder turns in the up direction (A leads B).
  function automatic logic [1:0] next_up(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  // One-bit move forward along the up sequence is an up step, one-bit move
  // backward is a down step; a two-bit move has no defined direction.
  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t res;
    res = '0;
    if (prev != cur) begin
      if (cur == next_up(prev)) begin
        res.valid = 1'b1;
      end else if (prev == next_up(cur)) begin
        res.valid = 1'b1;
        res.down  = 1'b1;
      end else begin
        res.illegal = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// rtl/quad_decoder_if.sv - step/status bundle from the quadrature decoder to its consumer
//
// Purpose: groups the decoder outputs so the step source and the up/down
// counter (plus status readers) connect through one port.
//   step_en   : one-cycle pulse per legal phase edge (counter en)
//   step_down : direction of the current pulse, 1 = down (counter down)
//   dir       : sticky direction of the most recent legal step
//   err       : sticky illegal-transition flag
//   err_cnt   : saturating illegal-transition count
// Modports: master (decoder drives), slave (consumer reads).

interface quad_decoder_if;
  import quad_decoder_pkg::*;

  logic                 step_en;
  logic                 step_down;
  logic                 dir;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output step_en,
    output step_down,
    output dir,
    output err,
    output err_cnt
  );

  modport slave (
    input step_en,
    input step_down,
    input dir,
    input err,
    input err_cnt
  );

endinterface

// File: rtl/quad_decoder_glitch_filter.sv
// rtl/quad_decoder_glitch_filter.sv - per-phase synchroniser and persistence glitch filter
//
// Purpose: brings one asynchronous encoder phase into the clock domain and
// only accepts a new level once it has been stable for FILT_LEN cycles.
// Ports:
//   clk_i    : system clock, rising edge
//   rst_ni   : asynchronous active-low reset
//   async_i  : raw phase input, asynchronous to clk_i
//   bypass_i : 1 = filtered output follows the synchroniser directly
//   filt_o   : filtered phase level (registered)

module glitch_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  input  logic bypass_i,
  output logic filt_o
);

  localparam int            CW       = $clog2(FILT_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   filt_q, filt_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (bypass_i) begin
      filt_d = sync_out;
      cnt_d  = '0;
    end else if (sync_out == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      // This cycle is the FILT_LEN-th consecutive one with the new level,
      // so the counter "reaches" FILT_LEN exactly as the output flips.
      filt_d = sync_out;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - x4 quadrature decoder with glitch filtering and illegal-move detection
//
// Purpose: filters encoder phases A/B, emits one step pulse plus direction
// per legal phase edge and counts two-bit (illegal) transitions.
// Ports:
//   clk50m  : 50 MHz system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   enc_a   : encoder phase A (asynchronous)
//   enc_b   : encoder phase B (asynchronous)
//   clr_err : synchronous clear of err / err_cnt
//   cnt_if  : master side of quad_decoder_if (step_en, step_down, dir, err, err_cnt)

module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic           clk50m,
  input  logic           rst_n,
  input  logic           enc_a,
  input  logic           enc_b,
  input  logic           clr_err,
  quad_decoder_if.master cnt_if
);

  // INIT lasts long enough for the synchronisers to fill and the filters to
  // settle on the encoder's resting position.
  localparam int            INIT_LEN  = SYNC_STAGES + FILT_LEN;
  localparam int            IW        = $clog2(INIT_LEN + 1);
  localparam logic [IW-1:0] INIT_LAST = IW'(INIT_LEN - 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        init_cnt_q, init_cnt_d;
  logic [1:0]           ab_q, ab_d;
  logic                 step_en_q, step_en_d;
  logic                 step_down_q, step_down_d;
  logic                 dir_q, dir_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic                 filt_a, filt_b;
  logic                 bypass;
  logic [1:0]           ab;
  step_t                dec;

  glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_filt_a (
    .clk_i    (clk50m),
    .rst_ni   (rst_n),
    .async_i  (enc_a),
    .bypass_i (bypass),
    .filt_o   (filt_a)
  );

  glitch_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_filt_b (
    .clk_i    (clk50m),
    .rst_ni   (rst_n),
    .async_i  (enc_b),
    .bypass_i (bypass),
    .filt_o   (filt_b)
  );

  assign ab     = {filt_a, filt_b};
  assign bypass = (state_q == INIT);
  assign dec    = decode_step(ab_q, ab);

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    ab_d        = ab_q;
    step_en_d   = 1'b0;
    step_down_d = 1'b0;
    dir_d       = dir_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      INIT: begin
        // The reference pair is captured only at the end so the position
        // found at reset release never produces a step.
        if (init_cnt_q == INIT_LAST) begin
          ab_d       = ab;
          init_cnt_d = '0;
          state_d    = TRACK;
        end else begin
          init_cnt_d = init_cnt_q + IW'(1);
        end
      end
      TRACK: begin
        ab_d        = ab;
        step_en_d   = dec.valid;
        step_down_d = dec.valid & dec.down;
        if (dec.valid) begin
          dir_d = dec.down;
        end
      end
      default: begin
        state_d = INIT;
      end
    endcase

    if (clr_err) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
    end

    // An illegal move overrides a simultaneous clear: the clear removes the
    // history, then this event is counted as the first one.
    if ((state_q == TRACK) && dec.illegal) begin
      err_d = 1'b1;
      if (clr_err) begin
        err_cnt_d = ERR_CNT_W'(1);
      end else if (err_cnt_q != ERR_CNT_MAX) begin
        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      init_cnt_q  <= '0;
      ab_q        <= PH_00;
      step_en_q   <= 1'b0;
      step_down_q <= 1'b0;
      dir_q       <= 1'b0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      ab_q        <= ab_d;
      step_en_q   <= step_en_d;
      step_down_q <= step_down_d;
      dir_q       <= dir_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign cnt_if.step_en   = step_en_q;
  assign cnt_if.step_down = step_down_q;
  assign cnt_if.dir       = dir_q;
  assign cnt_if.err       = err_q;
  assign cnt_if.err_cnt   = err_cnt_q;

endmodule
